// File: rtl/simd_mem_pkg.sv
// Shared types and constants for the SIMD image memory paths (load, downscale, store).
package simd_mem_pkg;

    typedef logic [7:0] pixel_t;

    localparam int unsigned DEF_SRC_W = 32;
    localparam int unsigned DEF_SRC_H = 32;
    localparam int unsigned DEF_DST_W = 16;
    localparam int unsigned DEF_DST_H = 16;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } wr_state_t;

    function automatic int unsigned beat_count(input int unsigned depth, input int unsigned n);
        return (depth + n - 1) / n;
    endfunction

endpackage

// File: rtl/simd_result_writer_if.sv
// N-lane SIMD BRAM write port: per-lane request/address/data plus a shared ready.
interface simd_result_writer_if
    import simd_mem_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned ADDR_BITS = 11
);

    logic [N-1:0]                wr_req;
    logic [N-1:0][ADDR_BITS-1:0] wr_addr;
    pixel_t [N-1:0]              wr_data;
    logic                        wr_ready;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/simd_lane_mux.sv
// Combinational lane selector: maps a linear pixel index to N lane requests/addresses/pixels.
module simd_lane_mux
    import simd_mem_pkg::*;
#(
    parameter int unsigned DST_W     = 16,
    parameter int unsigned DST_H     = 16,
    parameter int unsigned N         = 4,
    parameter int unsigned BASE_ADDR = 1024,
    parameter int unsigned ADDR_BITS = 11,
    parameter int unsigned IDX_W     = 10
) (
    input  logic [IDX_W-1:0]                  pix_idx,
    input  pixel_t [DST_H-1:0][DST_W-1:0]     image_in,
    output logic [N-1:0]                      lane_valid,
    output logic [N-1:0][ADDR_BITS-1:0]       lane_addr,
    output pixel_t [N-1:0]                    lane_data
);

    localparam int unsigned DEPTH = DST_W * DST_H;
    localparam int unsigned AW1   = ADDR_BITS + 1;
    localparam int unsigned BIT_W = $clog2(DEPTH * 8);

    logic [DEPTH*8-1:0]        flat;
    logic [N-1:0][IDX_W-1:0]   lane_idx;
    logic [N-1:0][BIT_W-1:0]   bit_off;

    // Row-major packing means pixel i sits at bit i*8, i.e. image_in[i/DST_W][i%DST_W].
    assign flat = image_in;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            lane_idx[k]   = pix_idx + IDX_W'(k);
            lane_valid[k] = lane_idx[k] < IDX_W'(DEPTH);
            lane_addr[k]  = ADDR_BITS'(AW1'(BASE_ADDR) + AW1'(lane_idx[k]));
            bit_off[k]    = lane_valid[k] ? (BIT_W'(lane_idx[k]) << 3) : '0;
            lane_data[k]  = flat[bit_off[k] +: 8];
        end
    end

endmodule

// File: rtl/simd_result_writer.sv
// Write-back engine: streams the DST_H x DST_W result into BRAM at BASE_ADDR, N pixels per beat.
// Optional running pixel checksum enabled by defining WRITER_CHECKSUM_EN.
module simd_result_writer
    import simd_mem_pkg::*;
#(
    parameter int unsigned DST_W     = DEF_DST_W,
    parameter int unsigned DST_H     = DEF_DST_H,
    parameter int unsigned N         = 4,
    parameter int unsigned BASE_ADDR = DEF_SRC_W * DEF_SRC_H,
    parameter int unsigned ADDR_BITS = $clog2(BASE_ADDR + DST_W * DST_H)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  pixel_t [DST_H-1:0][DST_W-1:0] image_in,
    simd_result_writer_if.master          wr,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   checksum
);

    localparam int unsigned DEPTH = DST_W * DST_H;
    localparam int unsigned IDX_W = $clog2(DEPTH + N) + 1;

    if (BASE_ADDR + DEPTH > (1 << ADDR_BITS)) begin : g_addr_range_err
        $error("simd_result_writer: BASE_ADDR + DST_W*DST_H exceeds 2**ADDR_BITS");
    end

    wr_state_t                   state_q, state_d;
    logic [IDX_W-1:0]            pix_idx_q, pix_idx_d;
    logic [IDX_W-1:0]            load_idx_c;
    logic [N-1:0]                req_q, req_d;
    logic [N-1:0][ADDR_BITS-1:0] addr_q, addr_d;
    pixel_t [N-1:0]              data_q, data_d;
    logic                        busy_d, done_d;
    logic                        load;
    logic [N-1:0]                lane_valid;
    logic [N-1:0][ADDR_BITS-1:0] lane_addr;
    pixel_t [N-1:0]              lane_data;

    // Index of the beat that would be loaded this cycle: 0 when starting, else the next beat.
    assign load_idx_c = (state_q == WRITE) ? pix_idx_q + IDX_W'(N) : '0;

    simd_lane_mux #(
        .DST_W     (DST_W),
        .DST_H     (DST_H),
        .N         (N),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_BITS (ADDR_BITS),
        .IDX_W     (IDX_W)
    ) u_lane_mux (
        .pix_idx    (load_idx_c),
        .image_in   (image_in),
        .lane_valid (lane_valid),
        .lane_addr  (lane_addr),
        .lane_data  (lane_data)
    );

`ifdef WRITER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic [15:0] beat_sum_c;

    always_comb begin
        beat_sum_c = '0;
        for (int k = 0; k < N; k++) begin
            if (req_q[k]) beat_sum_c = beat_sum_c + 16'(data_q[k]);
        end
    end

    always_comb begin
        csum_d = csum_q;
        if (state_q == IDLE && start) csum_d = '0;
        else if (state_q == WRITE && wr.wr_ready) csum_d = csum_q + beat_sum_c;
    end

    always_ff @(posedge clk) begin
        if (rst) csum_q <= '0;
        else     csum_q <= csum_d;
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    always_comb begin
        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        req_d     = req_q;
        addr_d    = addr_q;
        data_d    = data_q;
        busy_d    = busy;
        done_d    = done;
        load      = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_d  = '0;
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start) begin
                    pix_idx_d = '0;
                    load      = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (wr.wr_ready) begin
                    if (load_idx_c < IDX_W'(DEPTH)) begin
                        pix_idx_d = load_idx_c;
                        load      = 1'b1;
                    end else begin
                        req_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Lanes past the end of the image drop their request but keep their last addr/data.
        if (load) begin
            for (int k = 0; k < N; k++) begin
                req_d[k] = lane_valid[k];
                if (lane_valid[k]) begin
                    addr_d[k] = lane_addr[k];
                    data_d[k] = lane_data[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pix_idx_q <= '0;
            req_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_idx_q <= pix_idx_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign wr.wr_req  = req_q;
    assign wr.wr_addr = addr_q;
    assign wr.wr_data = data_q;

endmodule

// File: tb/tb_simd_result_writer.sv
// Directed bench for simd_result_writer: beat-level model plus literal checks on a 16x16 and a 3x3 instance.
module tb_simd_result_writer;
    import simd_mem_pkg::*;

    localparam int unsigned W     = 16;
    localparam int unsigned H     = 16;
    localparam int unsigned N     = 4;
    localparam int unsigned BASE  = 1024;
    localparam int unsigned AB    = 11;
    localparam int unsigned BEATS = beat_count(W * H, N);
    localparam int unsigned SW    = 3;
    localparam int unsigned SH    = 3;
    localparam int unsigned SBASE = 16;
    localparam int unsigned SAB   = 5;
`ifdef WRITER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic ready = 1'b1;
    logic s_start = 1'b0;
    pixel_t [H-1:0][W-1:0]   img;
    pixel_t [SH-1:0][SW-1:0] s_img;
    logic        busy, done, s_busy, s_done;
    logic [15:0] checksum, s_checksum;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    simd_result_writer_if #(.N(N), .ADDR_BITS(AB))  wr ();
    simd_result_writer_if #(.N(N), .ADDR_BITS(SAB)) s_wr ();
    assign wr.wr_ready   = ready;
    assign s_wr.wr_ready = 1'b1;

    simd_result_writer #(
        .DST_W(W), .DST_H(H), .N(N), .BASE_ADDR(BASE), .ADDR_BITS(AB)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .image_in(img), .wr(wr),
        .busy(busy), .done(done), .checksum(checksum)
    );

    simd_result_writer #(
        .DST_W(SW), .DST_H(SH), .N(N), .BASE_ADDR(SBASE), .ADDR_BITS(SAB)
    ) dut_small (
        .clk(clk), .rst(rst), .start(s_start), .image_in(s_img), .wr(s_wr),
        .busy(s_busy), .done(s_done), .checksum(s_checksum)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] pix(input int i);
        return 32'(img[4'(i / W)][4'(i % W)]);
    endfunction

    // Beat-level model: which beat the bus should be showing, and the running pixel sum.
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    int          m_beat = 0;
    int unsigned m_sum = 0;

    always @(posedge clk) begin : model
        int unsigned s;
        s = m_sum;
        if (rst) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_beat   <= 0;
            m_sum    <= 0;
        end else if (m_active) begin
            if (ready) begin
                for (int k = 0; k < N; k++) s = s + pix(m_beat * N + k);
                m_sum <= s & 32'hFFFF;
                if (m_beat == BEATS - 1) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_beat <= m_beat + 1;
                end
            end
        end else if (m_done) begin
            if (!start) m_done <= 1'b0;
        end else if (start) begin
            m_active <= 1'b1;
            m_beat   <= 0;
            m_sum    <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_done));
            chk("wr_req", 32'(wr.wr_req), m_active ? 32'hF : 32'h0);
            if (m_active) begin
                for (int k = 0; k < N; k++) begin
                    chk("wr_addr", 32'(wr.wr_addr[k]), BASE + 32'(m_beat * N + k));
                    chk("wr_data", 32'(wr.wr_data[k]), pix(m_beat * N + k));
                end
            end
            chk("checksum", 32'(checksum), CSUM_ON ? m_sum : 32'h0);
        end
    end

    // One run of the 16x16 instance; returns at the first cycle done is seen.
    task automatic run(input bit stall, input bit hold, input int exp_cycles, input bit chk_ends);
        int cyc = 0;
        @(negedge clk);
        start = 1'b1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            if (stall && cyc == 6) ready = 1'b0;
            if (stall && cyc == 9) ready = 1'b1;
            if (stall && cyc >= 6 && cyc <= 9) begin
                chk("stall_addr0", 32'(wr.wr_addr[0]), 1044);
                chk("stall_data0", 32'(wr.wr_data[0]), 20);
            end
            if (chk_ends && cyc == 1) begin
                for (int k = 0; k < N; k++) begin
                    chk("beat0_addr", 32'(wr.wr_addr[k]), 32'(1024 + k));
                    chk("beat0_data", 32'(wr.wr_data[k]), 32'(k));
                end
            end
            if (chk_ends && cyc == 64) begin
                for (int k = 0; k < N; k++) begin
                    chk("beat63_addr", 32'(wr.wr_addr[k]), 32'(1276 + k));
                    chk("beat63_data", 32'(wr.wr_data[k]), 32'(252 + k));
                end
            end
        end
        chk("run_cycles", 32'(cyc), 32'(exp_cycles));
    endtask

    initial begin
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'(r * 16 + c);
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++) s_img[r][c] = 8'(100 + r * 3 + c);

        repeat (2) @(negedge clk);
        chk("rst_wr_req", 32'(wr.wr_req), 0);
        chk("rst_wr_addr", 32'(wr.wr_addr), 0);
        chk("rst_wr_data", 32'(wr.wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_checksum", 32'(checksum), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Ramp image, ready tied high.
        run(1'b0, 1'b0, 65, 1'b1);
        chk("csum_ramp", 32'(checksum), CSUM_ON ? 32'h7F80 : 32'h0);
        repeat (3) @(negedge clk);

        // Backpressure on beat 5.
        run(1'b1, 1'b0, 68, 1'b0);
        repeat (3) @(negedge clk);

        // Reset in the middle of a run, then restart from the first address.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("beat10_addr0", 32'(wr.wr_addr[0]), 1064);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr_req", 32'(wr.wr_req), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);
        run(1'b0, 1'b0, 65, 1'b1);
        repeat (3) @(negedge clk);

        // start held through DONE: no retrigger until it drops.
        run(1'b0, 1'b1, 65, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("hold_done", 32'(done), 1);
            chk("hold_wr_req", 32'(wr.wr_req), 0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("release_done", 32'(done), 0);
        run(1'b0, 1'b0, 65, 1'b1);
        repeat (3) @(negedge clk);

        // All-0xFF image checksum.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 8'hFF;
        run(1'b0, 1'b1, 65, 1'b0);
        @(negedge clk);
        chk("csum_ff", 32'(checksum), CSUM_ON ? 32'hFF00 : 32'h0);
        start = 1'b0;
        repeat (3) @(negedge clk);

        // 3x3 instance: partial final beat.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("s_b0_req", 32'(s_wr.wr_req), 32'hF);
        chk("s_busy", 32'(s_busy), 1);
        for (int k = 0; k < N; k++) begin
            chk("s_b0_addr", 32'(s_wr.wr_addr[k]), 32'(16 + k));
            chk("s_b0_data", 32'(s_wr.wr_data[k]), 32'(100 + k));
        end
        @(negedge clk);
        chk("s_b1_req", 32'(s_wr.wr_req), 32'hF);
        for (int k = 0; k < N; k++) begin
            chk("s_b1_addr", 32'(s_wr.wr_addr[k]), 32'(20 + k));
            chk("s_b1_data", 32'(s_wr.wr_data[k]), 32'(104 + k));
        end
        @(negedge clk);
        chk("s_b2_req", 32'(s_wr.wr_req), 32'h1);
        chk("s_b2_addr0", 32'(s_wr.wr_addr[0]), 24);
        chk("s_b2_data0", 32'(s_wr.wr_data[0]), 108);
        chk("s_b2_addr1_held", 32'(s_wr.wr_addr[1]), 21);
        @(negedge clk);
        chk("s_done", 32'(s_done), 1);
        chk("s_done_busy", 32'(s_busy), 0);
        chk("s_done_req", 32'(s_wr.wr_req), 0);
        chk("s_checksum", 32'(s_checksum), CSUM_ON ? 32'd936 : 32'h0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
